// File: rtl/sid_regfile.sv
// sid_regfile: SID write-only register bank with decoded voice/filter fields,
// read-back mux and a decaying bus latch that write-only reads return.
module sid_regfile #(
  parameter logic [15:0] DECAY_TICKS = 16'd8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iCLKen,
  input  logic        iWR,
  input  logic        iRD,
  input  logic [4:0]  iAddr,
  input  logic [7:0]  iData,
  input  logic [7:0]  iPotX,
  input  logic [7:0]  iPotY,
  input  logic [7:0]  iOsc3,
  input  logic [7:0]  iEnv3,
  output logic [7:0]  oRdData,
  output logic [47:0] oFreq,
  output logic [35:0] oPW,
  output logic [23:0] oCtrl,
  output logic [23:0] oAD,
  output logic [23:0] oSR,
  output logic [2:0]  oCtrlWr,
  output logic [10:0] oFc,
  output logic [7:0]  oResFilt,
  output logic [7:0]  oModeVol
);
  logic [47:0] r_freq;
  logic [35:0] r_pw;
  logic [23:0] r_ctrl, r_ad, r_sr;
  logic [2:0]  r_ctrl_wr;
  logic [10:0] r_fc;
  logic [7:0]  r_res_filt, r_mode_vol, r_rd_data, r_latch;
  logic [15:0] r_decay;
  logic [7:0]  w_rd_src;

  assign w_rd_src = iAddr == 5'h19 ? iPotX :
                    iAddr == 5'h1A ? iPotY :
                    iAddr == 5'h1B ? iOsc3 :
                    iAddr == 5'h1C ? iEnv3 : r_latch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq     <= '0;
      r_pw       <= '0;
      r_ctrl     <= '0;
      r_ad       <= '0;
      r_sr       <= '0;
      r_ctrl_wr  <= '0;
      r_fc       <= '0;
      r_res_filt <= '0;
      r_mode_vol <= '0;
    end else begin
      for (int v = 0; v < 3; v++) begin
        r_ctrl_wr[v] <= iWR && iAddr == 5'(7 * v + 4);
        if (iWR) begin
          if (iAddr == 5'(7 * v))     r_freq[16 * v +: 8]     <= iData;
          if (iAddr == 5'(7 * v + 1)) r_freq[16 * v + 8 +: 8] <= iData;
          if (iAddr == 5'(7 * v + 2)) r_pw[12 * v +: 8]       <= iData;
          if (iAddr == 5'(7 * v + 3)) r_pw[12 * v + 8 +: 4]   <= iData[3:0];
          if (iAddr == 5'(7 * v + 4)) r_ctrl[8 * v +: 8]      <= iData;
          if (iAddr == 5'(7 * v + 5)) r_ad[8 * v +: 8]        <= iData;
          if (iAddr == 5'(7 * v + 6)) r_sr[8 * v +: 8]        <= iData;
        end
      end
      if (iWR && iAddr == 5'h15) r_fc[2:0]  <= iData[2:0];
      if (iWR && iAddr == 5'h16) r_fc[10:3] <= iData;
      if (iWR && iAddr == 5'h17) r_res_filt <= iData;
      if (iWR && iAddr == 5'h18) r_mode_vol <= iData;
    end
  end

  // A write always reloads the latch, even when it lands on a decay tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latch   <= '0;
      r_decay   <= '0;
      r_rd_data <= '0;
    end else begin
      if (iWR) begin
        r_latch <= iData;
        r_decay <= DECAY_TICKS;
      end else if (iCLKen && r_decay != 16'd0) begin
        r_decay <= r_decay - 16'd1;
        if (r_decay == 16'd1) r_latch <= '0;
      end
      if (iRD && !iWR) r_rd_data <= w_rd_src;
    end
  end

  assign oFreq    = r_freq;
  assign oPW      = r_pw;
  assign oCtrl    = r_ctrl;
  assign oAD      = r_ad;
  assign oSR      = r_sr;
  assign oCtrlWr  = r_ctrl_wr;
  assign oFc      = r_fc;
  assign oResFilt = r_res_filt;
  assign oModeVol = r_mode_vol;
  assign oRdData  = r_rd_data;
endmodule

// File: tb/tb_sid_regfile.sv
// tb_sid_regfile: random and directed stimulus against a register-array model
// of the SID register file, compared on every falling clock edge.
module tb_sid_regfile;
  localparam int D = 4;
  logic clk = 0, rst_n = 0;
  logic iCLKen = 0, iWR = 0, iRD = 0;
  logic [4:0] iAddr = 0;
  logic [7:0] iData = 0, iPotX = 0, iPotY = 0, iOsc3 = 0, iEnv3 = 0;
  logic [7:0] oRdData, oResFilt, oModeVol;
  logic [47:0] oFreq;
  logic [35:0] oPW;
  logic [23:0] oCtrl, oAD, oSR;
  logic [2:0] oCtrlWr;
  logic [10:0] oFc;
  int errors = 0, checks = 0;

  sid_regfile #(.DECAY_TICKS(16'(D))) dut (
    .clk(clk), .rst_n(rst_n), .iCLKen(iCLKen), .iWR(iWR), .iRD(iRD),
    .iAddr(iAddr), .iData(iData), .iPotX(iPotX), .iPotY(iPotY),
    .iOsc3(iOsc3), .iEnv3(iEnv3), .oRdData(oRdData), .oFreq(oFreq),
    .oPW(oPW), .oCtrl(oCtrl), .oAD(oAD), .oSR(oSR), .oCtrlWr(oCtrlWr),
    .oFc(oFc), .oResFilt(oResFilt), .oModeVol(oModeVol)
  );

  always #5 clk = ~clk;

  // Model: plain byte array of written values, last written byte and the
  // number of ticks seen since that write; fields are derived on compare.
  logic [7:0] m_reg [25];
  logic [7:0] m_last, m_rd;
  logic [2:0] m_cw;
  int m_ticks;

  function automatic logic [7:0] m_latch();
    return m_ticks < D ? m_last : 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 25; i++) m_reg[i] <= 8'h00;
      m_last <= 8'h00;
      m_rd <= 8'h00;
      m_cw <= 3'b000;
      m_ticks <= D;
    end else begin
      m_cw <= 3'b000;
      if (iWR) begin
        if (iAddr < 25) m_reg[iAddr] <= iData;
        if (iAddr == 4 || iAddr == 11 || iAddr == 18) m_cw <= 3'(1 << (iAddr / 7));
        m_last <= iData;
        m_ticks <= 0;
      end else if (iCLKen && m_ticks < D) m_ticks <= m_ticks + 1;
      if (iRD && !iWR)
        m_rd <= iAddr == 25 ? iPotX : iAddr == 26 ? iPotY :
                iAddr == 27 ? iOsc3 : iAddr == 28 ? iEnv3 : m_latch();
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("freq", 64'(oFreq), 64'({m_reg[15], m_reg[14], m_reg[8], m_reg[7], m_reg[1], m_reg[0]}));
    chk("pw", 64'(oPW), 64'({m_reg[17][3:0], m_reg[16], m_reg[10][3:0], m_reg[9], m_reg[3][3:0], m_reg[2]}));
    chk("ctrl", 64'(oCtrl), 64'({m_reg[18], m_reg[11], m_reg[4]}));
    chk("ad", 64'(oAD), 64'({m_reg[19], m_reg[12], m_reg[5]}));
    chk("sr", 64'(oSR), 64'({m_reg[20], m_reg[13], m_reg[6]}));
    chk("fc", 64'(oFc), 64'({m_reg[22], m_reg[21][2:0]}));
    chk("resfilt", 64'(oResFilt), 64'(m_reg[23]));
    chk("modevol", 64'(oModeVol), 64'(m_reg[24]));
    chk("ctrlwr", 64'(oCtrlWr), 64'(m_cw));
    chk("rddata", 64'(oRdData), 64'(m_rd));
  end

  // Each task starts #1 after a posedge and ends #1 after the capturing edge.
  task automatic cyc(input logic w, input logic r, input logic t, input logic [4:0] a, input logic [7:0] d);
    iWR = w; iRD = r; iCLKen = t; iAddr = a; iData = d;
    @(posedge clk); #1;
    iWR = 0; iRD = 0; iCLKen = 0;
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d); cyc(1, 0, 0, a, d); endtask
  task automatic rd(input logic [4:0] a); cyc(0, 1, 0, a, 8'h00); endtask
  task automatic tick(); cyc(0, 0, 1, 5'd0, 8'h00); endtask

  initial begin
    @(posedge clk); #1;
    chk("reset_freq", 64'(oFreq), 64'h0);
    chk("reset_rd", 64'(oRdData), 64'h0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 5'($urandom_range(0, 31)), 8'($urandom));
    chk("reset_hold_ctrl", 64'(oCtrl), 64'h0);
    rst_n = 1;
    wr(5'h00, 8'h34);
    wr(5'h01, 8'h12);
    chk("freq0_lit", 64'(oFreq[15:0]), 64'h1234);
    wr(5'h03, 8'hFF); wr(5'h02, 8'hAB); wr(5'h15, 8'hFF); wr(5'h16, 8'h80);
    chk("pw0_lit", 64'(oPW[11:0]), 64'hFAB);
    chk("fc_lit", 64'(oFc), 64'h407);
    wr(5'h0B, 8'h41);
    chk("ctrlwr_lit1", 64'(oCtrlWr), 64'h2);
    wr(5'h0B, 8'h41);
    chk("ctrlwr_lit2", 64'(oCtrlWr), 64'h2);
    chk("ctrl1_lit", 64'(oCtrl[15:8]), 64'h41);
    tick();
    chk("ctrlwr_clear", 64'(oCtrlWr), 64'h0);
    iOsc3 = 8'h5A; iEnv3 = 8'hC3;
    rd(5'h1B);
    chk("osc3_lit", 64'(oRdData), 64'h5A);
    tick(); tick();
    chk("rd_hold", 64'(oRdData), 64'h5A);
    rd(5'h1C);
    chk("env3_lit", 64'(oRdData), 64'hC3);
    wr(5'h1F, 8'h77);
    rd(5'h00);
    chk("latch_lit", 64'(oRdData), 64'h77);
    tick(); tick(); tick();
    rd(5'h00);
    chk("latch_3ticks", 64'(oRdData), 64'h77);
    tick();
    rd(5'h00);
    chk("latch_decayed", 64'(oRdData), 64'h00);
    wr(5'h1F, 8'h77);
    tick(); tick();
    cyc(1, 0, 1, 5'h1F, 8'h55);
    tick(); tick(); tick();
    rd(5'h1D);
    chk("reload_3ticks", 64'(oRdData), 64'h55);
    tick();
    rd(5'h1D);
    chk("reload_decayed", 64'(oRdData), 64'h00);
    rd(5'h1B);
    cyc(1, 1, 0, 5'h18, 8'h0F);
    chk("prio_modevol", 64'(oModeVol), 64'h0F);
    chk("prio_rd_hold", 64'(oRdData), 64'h5A);
    #1 rst_n = 0;
    #1 chk("async_freq", 64'(oFreq), 64'h0);
    chk("async_modevol", 64'(oModeVol), 64'h0);
    chk("async_rd", 64'(oRdData), 64'h0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      iPotX = 8'($urandom); iPotY = 8'($urandom);
      iOsc3 = 8'($urandom); iEnv3 = 8'($urandom);
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
          5'($urandom), 8'($urandom));
      if (i == 1500) begin
        #2 rst_n = 0;
        #2 rst_n = 1;
      end
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
